// File: rtl/lane_arbiter_rr_if.sv
// Handshake bundle for the four-lane round-robin arbiter: four valid/data/ready
// input lanes and one registered, lane-tagged output lane.
interface lane_arbiter_rr_if #(
  parameter int DATA_W = 8
);
  logic              valid_in0;
  logic              valid_in1;
  logic              valid_in2;
  logic              valid_in3;
  logic [DATA_W-1:0] data_in0;
  logic [DATA_W-1:0] data_in1;
  logic [DATA_W-1:0] data_in2;
  logic [DATA_W-1:0] data_in3;
  logic              ready_out0;
  logic              ready_out1;
  logic              ready_out2;
  logic              ready_out3;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        lane_out;
  logic              ready_in;

  // Arbiter side
  modport slave (
    input  valid_in0, valid_in1, valid_in2, valid_in3,
    input  data_in0, data_in1, data_in2, data_in3,
    input  ready_in,
    output ready_out0, ready_out1, ready_out2, ready_out3,
    output valid_out, data_out, lane_out
  );

  // Lane sources plus the downstream consumer
  modport master (
    output valid_in0, valid_in1, valid_in2, valid_in3,
    output data_in0, data_in1, data_in2, data_in3,
    output ready_in,
    input  ready_out0, ready_out1, ready_out2, ready_out3,
    input  valid_out, data_out, lane_out
  );
endinterface

// File: rtl/lane_arbiter_rr.sv
// Four-lane round-robin arbiter: grants one lane for a burst of at most
// MAX_BURST beats and forwards them onto one registered, lane-tagged output.
module lane_arbiter_rr #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input logic              aclk,
  input logic              reset,
  lane_arbiter_rr_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [2:0] LAST_BEAT = 3'(MAX_BURST - 1);

  state_t            state;
  logic [1:0]        gnt;
  logic [1:0]        ptr;
  logic [1:0]        pick;
  logic [2:0]        burst_cnt;
  logic [3:0]        valid_vec;
  logic [3:0]        ready_vec;
  logic [DATA_W-1:0] lane_data [4];
  logic              out_free;
  logic              accept;
  logic              release_now;

  assign valid_vec    = {bus.valid_in3, bus.valid_in2, bus.valid_in1, bus.valid_in0};
  assign lane_data[0] = bus.data_in0;
  assign lane_data[1] = bus.data_in1;
  assign lane_data[2] = bus.data_in2;
  assign lane_data[3] = bus.data_in3;

  assign out_free    = !bus.valid_out || bus.ready_in;
  assign accept      = (state == GRANT) && valid_vec[gnt] && ready_vec[gnt];
  assign release_now = (state == GRANT) &&
                       (!valid_vec[gnt] || (accept && burst_cnt == LAST_BEAT));

  always_comb begin
    ready_vec = '0;
    if (state == GRANT && out_free) ready_vec[gnt] = 1'b1;
  end

  assign bus.ready_out0 = ready_vec[0];
  assign bus.ready_out1 = ready_vec[1];
  assign bus.ready_out2 = ready_vec[2];
  assign bus.ready_out3 = ready_vec[3];

  // Scan from the farthest offset down so the lane closest to ptr wins.
  always_comb begin
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (valid_vec[ptr + 2'(k)]) pick = ptr + 2'(k);
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      gnt           <= '0;
      ptr           <= '0;
      burst_cnt     <= '0;
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
      bus.lane_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|valid_vec) begin
            gnt       <= pick;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (accept) burst_cnt <= burst_cnt + 3'd1;
          if (release_now) begin
            ptr   <= gnt + 2'd1;
            state <= IDLE;
          end
        end
      endcase

      // A stalled output beat simply holds; nothing is buffered behind it.
      if (accept) begin
        bus.valid_out <= 1'b1;
        bus.data_out  <= lane_data[gnt];
        bus.lane_out  <= gnt;
      end else if (out_free) begin
        bus.valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lane_arbiter_rr.sv
// Directed bench for lane_arbiter_rr: lane sources hold each beat until it is
// accepted, and every consumed output beat is logged with its cycle number.
module tb_lane_arbiter_rr;

  logic aclk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  logic [7:0] src_data [4][16];
  int         src_len  [4];
  int         src_idx  [4];
  logic [9:0] obs_q    [$];
  int         obs_cyc  [$];

  always #5 aclk = ~aclk;

  lane_arbiter_rr_if #(.DATA_W(8)) bus ();

  lane_arbiter_rr #(.DATA_W(8), .MAX_BURST(4)) dut (
    .aclk  (aclk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [7:0] src_at(int l);
    if (src_idx[l] < src_len[l]) return src_data[l][src_idx[l]];
    return 8'h00;
  endfunction

  task automatic drive_sources();
    bus.valid_in0 = (src_idx[0] < src_len[0]);
    bus.valid_in1 = (src_idx[1] < src_len[1]);
    bus.valid_in2 = (src_idx[2] < src_len[2]);
    bus.valid_in3 = (src_idx[3] < src_len[3]);
    bus.data_in0  = src_at(0);
    bus.data_in1  = src_at(1);
    bus.data_in2  = src_at(2);
    bus.data_in3  = src_at(3);
  endtask

  task automatic load_lane(int l, int n, logic [7:0] base);
    for (int k = 0; k < n; k++) src_data[l][k] = base + 8'(k);
    src_len[l] = n;
    src_idx[l] = 0;
  endtask

  // Called at a falling edge; samples handshakes just before the rising edge.
  task automatic run_cycle();
    logic [3:0] fire;
    #4;
    fire = {bus.valid_in3 && bus.ready_out3, bus.valid_in2 && bus.ready_out2,
            bus.valid_in1 && bus.ready_out1, bus.valid_in0 && bus.ready_out0};
    if (bus.valid_out && bus.ready_in) begin
      obs_q.push_back({bus.lane_out, bus.data_out});
      obs_cyc.push_back(cyc);
    end
    @(negedge aclk);
    cyc++;
    for (int l = 0; l < 4; l++) if (fire[l]) src_idx[l]++;
    drive_sources();
  endtask

  task automatic apply_reset();
    reset        = 1'b1;
    bus.ready_in = 1'b1;
    for (int l = 0; l < 4; l++) begin
      src_len[l] = 0;
      src_idx[l] = 0;
    end
    drive_sources();
    @(negedge aclk);
    @(negedge aclk);
    cyc += 2;
    reset = 1'b0;
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.valid_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid_out: got %0b expected 0", bus.valid_out);
    end
    checks++;
    if ({bus.lane_out, bus.data_out} !== 10'h000) begin
      errors++;
      $display("[TB] FAIL reset_lane_data: got %0h expected 0", {bus.lane_out, bus.data_out});
    end
    checks++;
    if ({bus.ready_out3, bus.ready_out2, bus.ready_out1, bus.ready_out0} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ready_out: got %4b expected 0000",
               {bus.ready_out3, bus.ready_out2, bus.ready_out1, bus.ready_out0});
    end
  endtask

  task automatic test_single_lane();
    int c0;
    logic [9:0] exp;
    apply_reset();
    load_lane(2, 8, 8'h10);
    drive_sources();
    c0 = cyc;
    repeat (14) run_cycle();
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("[TB] FAIL single_count: got %0d expected 8", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 8; k++) begin
      exp = {2'd2, 8'h10 + 8'(k)};
      checks++;
      if (obs_q[k] !== exp) begin
        errors++;
        $display("[TB] FAIL single_beat%0d: got %0h expected %0h", k, obs_q[k], exp);
      end
    end
    if (obs_cyc.size() >= 5) begin
      checks++;
      if (obs_cyc[0] != c0 + 2) begin
        errors++;
        $display("[TB] FAIL single_latency: got %0d expected %0d", obs_cyc[0] - c0, 2);
      end
      checks++;
      if (obs_cyc[3] != c0 + 5) begin
        errors++;
        $display("[TB] FAIL single_burst_end: got %0d expected %0d", obs_cyc[3] - c0, 5);
      end
      checks++;
      if (obs_cyc[4] != c0 + 7) begin
        errors++;
        $display("[TB] FAIL single_bubble: got %0d expected %0d", obs_cyc[4] - c0, 7);
      end
    end
  endtask

  task automatic test_saturated();
    int n;
    int lane;
    logic [9:0] exp;
    apply_reset();
    for (int l = 0; l < 4; l++) load_lane(l, 8, 8'(l * 16));
    drive_sources();
    repeat (46) run_cycle();
    checks++;
    if (obs_q.size() != 32) begin
      errors++;
      $display("[TB] FAIL sat_count: got %0d expected 32", obs_q.size());
    end
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 4; k++) begin
        n    = b * 4 + k;
        lane = b % 4;
        exp  = {2'(lane), 8'(lane * 16 + (b / 4) * 4 + k)};
        if (n < obs_q.size()) begin
          checks++;
          if (obs_q[n] !== exp) begin
            errors++;
            $display("[TB] FAIL sat_beat%0d: got %0h expected %0h", n, obs_q[n], exp);
          end
        end
      end
    end
    if (obs_cyc.size() >= 5) begin
      checks++;
      if (obs_cyc[3] - obs_cyc[0] != 3 || obs_cyc[4] - obs_cyc[3] != 2) begin
        errors++;
        $display("[TB] FAIL sat_spacing: got %0d/%0d expected 3/2",
                 obs_cyc[3] - obs_cyc[0], obs_cyc[4] - obs_cyc[3]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] exp;
    apply_reset();
    load_lane(3, 4, 8'h30);
    drive_sources();
    repeat (4) run_cycle();
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("[TB] FAIL bp_before_stall: got %0d expected 2", obs_q.size());
    end
    bus.ready_in = 1'b0;
    for (int s = 0; s < 5; s++) begin
      run_cycle();
      checks++;
      if ({bus.valid_out, bus.lane_out, bus.data_out} !== {1'b1, 2'd3, 8'h32}) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got %0h expected %0h", s,
                 {bus.valid_out, bus.lane_out, bus.data_out}, {1'b1, 2'd3, 8'h32});
      end
      checks++;
      if ({bus.ready_out3, bus.ready_out2, bus.ready_out1, bus.ready_out0} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL bp_ready%0d: got %4b expected 0000", s,
                 {bus.ready_out3, bus.ready_out2, bus.ready_out1, bus.ready_out0});
      end
    end
    bus.ready_in = 1'b1;
    repeat (6) run_cycle();
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d expected 4", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 4; k++) begin
      exp = {2'd3, 8'h30 + 8'(k)};
      checks++;
      if (obs_q[k] !== exp) begin
        errors++;
        $display("[TB] FAIL bp_beat%0d: got %0h expected %0h", k, obs_q[k], exp);
      end
    end
  endtask

  task automatic test_early_release();
    int c0;
    logic [9:0] exp_seq [8];
    exp_seq = '{{2'd1, 8'hA0}, {2'd1, 8'hA1}, {2'd3, 8'hB0}, {2'd3, 8'hB1},
                {2'd3, 8'hB2}, {2'd3, 8'hB3}, {2'd1, 8'hA2}, {2'd1, 8'hA3}};
    apply_reset();
    load_lane(1, 2, 8'hA0);
    load_lane(3, 4, 8'hB0);
    drive_sources();
    c0 = cyc;
    repeat (4) run_cycle();
    // Lane 1 re-requests in the arbitration cycle right after its release
    src_data[1][2] = 8'hA2;
    src_data[1][3] = 8'hA3;
    src_len[1]     = 4;
    drive_sources();
    repeat (12) run_cycle();
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("[TB] FAIL early_count: got %0d expected 8", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 8; k++) begin
      checks++;
      if (obs_q[k] !== exp_seq[k]) begin
        errors++;
        $display("[TB] FAIL early_beat%0d: got %0h expected %0h", k, obs_q[k], exp_seq[k]);
      end
    end
    if (obs_cyc.size() >= 3) begin
      checks++;
      if (obs_cyc[2] != c0 + 6) begin
        errors++;
        $display("[TB] FAIL early_lane3_start: got %0d expected %0d", obs_cyc[2] - c0, 6);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int c1;
    apply_reset();
    load_lane(1, 8, 8'h50);
    drive_sources();
    repeat (8) run_cycle();
    checks++;
    if ({bus.valid_out, bus.lane_out, bus.data_out, bus.ready_out1} !== {1'b1, 2'd1, 8'h55, 1'b1}) begin
      errors++;
      $display("[TB] FAIL midrst_before: got %0h expected %0h",
               {bus.valid_out, bus.lane_out, bus.data_out, bus.ready_out1},
               {1'b1, 2'd1, 8'h55, 1'b1});
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.valid_out, bus.lane_out, bus.data_out} !== 11'h000) begin
      errors++;
      $display("[TB] FAIL midrst_outputs: got %0h expected 0", {bus.valid_out, bus.lane_out, bus.data_out});
    end
    checks++;
    if ({bus.ready_out3, bus.ready_out2, bus.ready_out1, bus.ready_out0} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midrst_ready: got %4b expected 0000",
               {bus.ready_out3, bus.ready_out2, bus.ready_out1, bus.ready_out0});
    end
    @(negedge aclk);
    @(negedge aclk);
    cyc += 2;
    reset = 1'b0;
    for (int l = 0; l < 4; l++) begin
      src_len[l] = 0;
      src_idx[l] = 0;
    end
    load_lane(0, 1, 8'h60);
    load_lane(3, 1, 8'h63);
    obs_q.delete();
    obs_cyc.delete();
    drive_sources();
    c1 = cyc;
    repeat (8) run_cycle();
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("[TB] FAIL midrst_count: got %0d expected 2", obs_q.size());
    end
    if (obs_q.size() >= 2) begin
      checks++;
      if (obs_q[0] !== {2'd0, 8'h60} || obs_q[1] !== {2'd3, 8'h63}) begin
        errors++;
        $display("[TB] FAIL midrst_order: got %0h,%0h expected 060,363", obs_q[0], obs_q[1]);
      end
      checks++;
      if (obs_cyc[0] != c1 + 2) begin
        errors++;
        $display("[TB] FAIL midrst_first_grant: got %0d expected %0d", obs_cyc[0] - c1, 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_saturated();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
